// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and helpers for packed multi-lane buses.
package cpu_pkg;

   localparam int XLEN      = 32;
   localparam int REG_COUNT = 32;

   // Lowest bit position of lane 'lane' in a bus of lanes 'lane_w' bits wide.
   function automatic int lane_lsb(input int lane, input int lane_w);
      return lane * lane_w;
   endfunction

endpackage

// File: rtl/reg_word.sv
// One storage word of the register file: a load-enabled register with
// asynchronous active-low clear.
module reg_word #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] word_d;
   logic [WIDTH-1:0] word_q;

   always_comb begin
      word_d = word_q;
      if (load) begin
         word_d = d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign q = word_q;

endmodule

// File: rtl/reg_file.sv
// Multi-port register file: one synchronous write port, NUM_RD combinational
// read ports, optional hardwired-zero entry 0 and write-to-read forwarding.
module reg_file
   import cpu_pkg::*;
#(
   parameter int WIDTH    = XLEN,
   parameter int DEPTH    = REG_COUNT,
   parameter int NUM_RD   = 2,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [AW-1:0]            waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [NUM_RD*AW-1:0]     raddr,
   output logic [NUM_RD*WIDTH-1:0]  rdata,
   output logic                     wr_zero_err
);

   logic [WIDTH-1:0] word_val [DEPTH];
   logic             wr_zero_err_d;
   logic             wr_zero_err_q;

   // With ZERO_REG the zero entry has no storage at all, so writes to it vanish.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      if (ZERO_REG && i == 0) begin : g_zero
         assign word_val[i] = '0;
      end else begin : g_reg
         reg_word #(
            .WIDTH(WIDTH)
         ) u_word (
            .clk  (clk),
            .rst  (rst),
            .load (we && (waddr == AW'(i))),
            .d    (wdata),
            .q    (word_val[i])
         );
      end
   end

   // Forwarding is gated by rst so that lanes read zero throughout reset.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      localparam int AL = lane_lsb(k, AW);
      localparam int DL = lane_lsb(k, WIDTH);

      logic [AW-1:0]    ra;
      logic             is_zero;
      logic             hit;
      logic [WIDTH-1:0] lane;

      assign ra      = raddr[AL +: AW];
      assign is_zero = ZERO_REG && (ra == '0);
      assign hit     = BYPASS && rst && we && (waddr == ra) && !is_zero;

      always_comb begin
         lane = word_val[ra];
         if (hit) begin
            lane = wdata;
         end
         if (is_zero) begin
            lane = '0;
         end
      end

      assign rdata[DL +: WIDTH] = lane;
   end

   always_comb begin
      wr_zero_err_d = ZERO_REG && we && (waddr == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_zero_err_q <= 1'b0;
      end else begin
         wr_zero_err_q <= wr_zero_err_d;
      end
   end

   assign wr_zero_err = wr_zero_err_q;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: three configurations driven side by side, checked against
// directed vectors and an array-based model of the word contents.
module tb_reg_file;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Shared stimulus for the 32x32 instances
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [9:0]  raddr;
   logic [63:0] rdata_a, rdata_b;
   logic        err_a, err_b;

   // Stimulus for the 8-bit, 4-word, 3-port instance
   logic        we_c;
   logic [1:0]  waddr_c;
   logic [7:0]  wdata_c;
   logic [5:0]  raddr_c;
   logic [23:0] rdata_c;
   logic        err_c;

   reg_file #(.WIDTH(XLEN), .DEPTH(REG_COUNT), .NUM_RD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_a), .wr_zero_err(err_a));

   reg_file #(.WIDTH(XLEN), .DEPTH(REG_COUNT), .NUM_RD(2), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_b), .wr_zero_err(err_b));

   reg_file #(.WIDTH(8), .DEPTH(4), .NUM_RD(3), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_c (
      .clk(clk), .rst(rst), .we(we_c), .waddr(waddr_c), .wdata(wdata_c),
      .raddr(raddr_c), .rdata(rdata_c), .wr_zero_err(err_c));

   int tests = 0;
   int fails = 0;

   // Reference contents of each instance, plus the expected error flags
   logic [31:0] mem_a [32];
   logic [31:0] mem_b [32];
   logic [7:0]  mem_c [4];
   logic        err_a_exp, err_c_exp;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  ra0, ra1;
      logic [31:0] a0, a1, b0, b1;
      logic        err_after;
   } vec_t;

   vec_t vecs [8];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      for (int i = 0; i < 4; i++) mem_c[i] = '0;
      err_a_exp = 1'b0;
      err_c_exp = 1'b0;
   endtask

   function automatic logic [31:0] exp_a(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (rst && we && waddr == a) return wdata;
      return mem_a[a];
   endfunction

   function automatic logic [31:0] exp_b(input logic [4:0] a);
      return mem_b[a];
   endfunction

   function automatic logic [7:0] exp_c(input logic [1:0] a);
      if (a == 2'd0) return 8'h0;
      if (rst && we_c && waddr_c == a) return wdata_c;
      return mem_c[a];
   endfunction

   // Advance one rising edge and apply the write rules to the model
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         if (we) begin
            if (waddr != 5'd0) mem_a[waddr] = wdata;
            mem_b[waddr] = wdata;
         end
         if (we_c && waddr_c != 2'd0) mem_c[waddr_c] = wdata_c;
         err_a_exp = we && (waddr == 5'd0);
         err_c_exp = we_c && (waddr_c == 2'd0);
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      for (int k = 0; k < 2; k++) begin
         check_output($sformatf("%s A lane%0d", tag, k), rdata_a[k*32 +: 32], exp_a(raddr[k*5 +: 5]));
         check_output($sformatf("%s B lane%0d", tag, k), rdata_b[k*32 +: 32], exp_b(raddr[k*5 +: 5]));
      end
      for (int k = 0; k < 3; k++) begin
         check_output($sformatf("%s C lane%0d", tag, k), {24'h0, rdata_c[k*8 +: 8]},
                      {24'h0, exp_c(raddr_c[k*2 +: 2])});
      end
      check_output({tag, " A err"}, {31'h0, err_a}, {31'h0, err_a_exp});
      check_output({tag, " B err"}, {31'h0, err_b}, 32'h0);
      check_output({tag, " C err"}, {31'h0, err_c}, {31'h0, err_c_exp});
   endtask

   task automatic apply_stimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] r0, input logic [4:0] r1);
      @(negedge clk);
      we    = w;
      waddr = wa;
      wdata = wd;
      raddr = {r1, r0};
      #1;
   endtask

   initial begin
      rst = 1'b0;
      we = 1'b0; waddr = '0; wdata = '0; raddr = {5'd31, 5'd7};
      we_c = 1'b0; waddr_c = '0; wdata_c = '0; raddr_c = 6'b11_10_01;
      model_reset();

      vecs[0] = '{1'b1, 5'd7,  32'h12345678, 5'd7, 5'd31, 32'h12345678, 32'h0,        32'h0,        32'h0,        1'b0};
      vecs[1] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd7, 5'd31, 32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'h0,        1'b0};
      vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd31, 32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 1'b0};
      vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd5,  32'h0,        32'h0,        32'h0,        32'h0,        1'b1};
      vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd9,  32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b0};
      vecs[5] = '{1'b1, 5'd3,  32'h11,       5'd3, 5'd7,  32'h11,       32'h12345678, 32'h0,        32'h12345678, 1'b0};
      vecs[6] = '{1'b1, 5'd3,  32'h22,       5'd3, 5'd3,  32'h22,       32'h22,       32'h11,       32'h11,       1'b0};
      vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd31, 32'h22,       32'hCAFEF00D, 32'h22,       32'hCAFEF00D, 1'b0};

      #2;
      check_model("reset");
      @(negedge clk);
      rst = 1'b1;

      // Directed write/read, zero entry and bypass vectors
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra0, vecs[i].ra1);
         check_output($sformatf("vec%0d A lane0", i), rdata_a[31:0],  vecs[i].a0);
         check_output($sformatf("vec%0d A lane1", i), rdata_a[63:32], vecs[i].a1);
         check_output($sformatf("vec%0d B lane0", i), rdata_b[31:0],  vecs[i].b0);
         check_output($sformatf("vec%0d B lane1", i), rdata_b[63:32], vecs[i].b1);
         tick();
         check_output($sformatf("vec%0d A err", i), {31'h0, err_a}, {31'h0, vecs[i].err_after});
         check_output($sformatf("vec%0d B err", i), {31'h0, err_b}, 32'h0);
      end

      // Hold: write enable low for ten cycles must leave word 9 alone
      apply_stimulus(1'b0, 5'd9, 32'hAA, 5'd9, 5'd9);
      for (int i = 0; i < 10; i++) begin
         tick();
         check_model("hold");
      end
      check_output("hold word9", rdata_a[31:0], 32'h0);

      // Reset mid-operation clears storage immediately and blocks forwarding
      apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
      tick();
      apply_stimulus(1'b0, 5'd5, 32'h0, 5'd5, 5'd5);
      check_output("pre-reset word5", rdata_a[31:0], 32'hDEADBEEF);
      #1;
      rst = 1'b0;
      we = 1'b1; wdata = 32'h12121212;
      model_reset();
      #1;
      check_output("in-reset A word5", rdata_a[31:0], 32'h0);
      check_output("in-reset B word5", rdata_b[31:0], 32'h0);
      check_model("in-reset");
      tick();
      tick();
      check_model("in-reset edge");
      @(negedge clk);
      rst = 1'b1;
      we = 1'b0;
      #1;
      check_output("post-reset word5", rdata_a[31:0], 32'h0);
      check_model("post-reset");

      // Narrow configuration: fill words 1..3 and read all three lanes at once
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         we_c = 1'b1; waddr_c = 2'(i); wdata_c = 8'(8'hA0 + 8'h11 * i);
         tick();
      end
      @(negedge clk);
      we_c = 1'b0; raddr_c = {2'd3, 2'd2, 2'd1};
      #1;
      check_output("sweep 3/2/1", {8'h0, rdata_c}, 32'h00D3C2B1);
      raddr_c = {2'd0, 2'd2, 2'd2};
      #1;
      check_output("sweep 0/2/2", {8'h0, rdata_c}, 32'h0000C2C2);

      // Random traffic against the model, biased towards the zero entry
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         we      = 1'($urandom);
         waddr   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         wdata   = $urandom;
         raddr   = {5'($urandom), ($urandom_range(0, 7) == 0) ? waddr : 5'($urandom)};
         we_c    = 1'($urandom);
         waddr_c = 2'($urandom);
         wdata_c = 8'($urandom);
         raddr_c = 6'($urandom);
         #1;
         check_model("rnd pre");
         tick();
         check_model("rnd post");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
